// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock divider: divisor type, per-channel config, half-period helper.
// Purely declarative; no latency or flow control of its own.
package clk_div_pkg;

    localparam int DW = 16;

    typedef logic [DW-1:0] div_t;

    typedef struct packed {
        div_t div;
        div_t phase;
    } ch_cfg_t;

    function automatic div_t half_period(input div_t d);
        logic [DW:0] w_sum;
        w_sum = {1'b0, d} + (DW+1)'(1);
        return w_sum[DW:1];
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, pending divisor, boundary apply, registered div_clk/tick.
// Outputs track the counter with one flop stage; i_load must only be raised while o_pend is low.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter div_t P_DEF_DIV = div_t'(2)
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_run,
    input  logic    i_sync,
    input  logic    i_load,
    input  ch_cfg_t i_cfg,
    output logic    o_div_clk,
    output logic    o_tick,
    output logic    o_pend
);

    div_t    r_cnt;
    div_t    r_cur;
    div_t    r_phase;
    ch_cfg_t r_pcfg;
    logic    r_pend;
    logic    r_act;
    logic    r_div_clk;
    logic    r_tick;

    logic    w_wrap;
    logic    w_apply;
    div_t    w_cur;
    div_t    w_phase;
    div_t    w_cnt;

    always_comb begin
        w_wrap  = r_act && (r_cnt == r_cur - div_t'(1));
        // A pending divisor only lands where a new period starts anyway.
        w_apply = r_pend && (w_wrap || i_sync || !r_act);
        w_cur   = w_apply ? r_pcfg.div   : r_cur;
        w_phase = w_apply ? r_pcfg.phase : r_phase;
        if (!i_run) begin
            w_cnt = '0;
        end else if (!r_act || i_sync || w_wrap) begin
            w_cnt = w_phase;
        end else begin
            w_cnt = r_cnt + div_t'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_cur     <= P_DEF_DIV;
            r_phase   <= '0;
            r_pcfg    <= '0;
            r_pend    <= 1'b0;
            r_act     <= 1'b0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_act     <= i_run;
            r_cnt     <= w_cnt;
            r_cur     <= w_cur;
            r_phase   <= w_phase;
            if (i_load) begin
                r_pcfg <= i_cfg;
            end
            r_pend    <= i_load | (r_pend & ~w_apply);
            r_div_clk <= i_run && (w_cnt < half_period(w_cur));
            r_tick    <= i_run && (w_cnt == w_cur - div_t'(1));
        end
    end

    assign o_div_clk = r_div_clk;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// Runtime-programmable NCH-channel clock divider with glitch-free divisor updates and shared sync.
// cfg_ready drops while the addressed channel holds an unapplied divisor; CLK_DIV_MULTI_PHASE_EN adds per-channel start phase.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = clk_div_pkg::DW,
    parameter int DEF_DIV = 2,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] run,
    input  logic           sync,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_div,
`ifdef CLK_DIV_MULTI_PHASE_EN
    input  logic [DW-1:0]  cfg_phase,
`endif
    output logic           cfg_err,
    output logic [NCH-1:0] div_clk,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    logic [NCH-1:0]      w_pend;
    logic [(1<<CW)-1:0]  w_pend_pad;
    logic                w_ch_ok;
    logic                w_bad;
    logic                w_fire;
    ch_cfg_t             w_cfg;
    logic                r_err;

    always_comb begin
        w_pend_pad          = '0;
        w_pend_pad[NCH-1:0] = w_pend;
        w_ch_ok             = int'(cfg_ch) < NCH;
        w_cfg.div           = cfg_div;
`ifdef CLK_DIV_MULTI_PHASE_EN
        w_cfg.phase         = cfg_phase;
        w_bad               = !w_ch_ok || (cfg_div == '0) || (cfg_phase >= cfg_div);
`else
        w_cfg.phase         = '0;
        w_bad               = !w_ch_ok || (cfg_div == '0);
`endif
        // Out-of-range channels are always accepted so the request can be rejected with cfg_err.
        cfg_ready           = w_ch_ok ? ~w_pend_pad[cfg_ch] : 1'b1;
        w_fire              = cfg_valid & cfg_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_fire & w_bad;
        end
    end

    assign cfg_err = r_err;
    assign pend    = w_pend;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_ch #(
            .P_DEF_DIV (div_t'(DEF_DIV))
        ) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_run     (run[g]),
            .i_sync    (sync),
            .i_load    (w_fire & ~w_bad & (cfg_ch == CW'(g))),
            .i_cfg     (w_cfg),
            .o_div_clk (div_clk[g]),
            .o_tick    (tick[g]),
            .o_pend    (w_pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (three channels so an out-of-range cfg_ch is representable).
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] run;
    logic           sync;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_err;
    logic [NCH-1:0] div_clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NCH     (NCH),
        .DW      (DW),
        .DEF_DIV (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .tick      (tick),
        .pend      (pend)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [2:0] e_div, input logic [2:0] e_tick,
                            input logic [2:0] e_pend);
        step();
        chk({tag, ".div_clk"}, 32'(div_clk), 32'(e_div));
        chk({tag, ".tick"},    32'(tick),    32'(e_tick));
        chk({tag, ".pend"},    32'(pend),    32'(e_pend));
    endtask

    task automatic cfg(input logic v, input int ch, input int d);
        cfg_valid = v;
        cfg_ch    = CW'(ch);
        cfg_div   = DW'(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        run  = '0;
        sync = 1'b0;
        cfg(1'b0, 0, 0);
        step();
        step();
        chk("rst.div_clk", 32'(div_clk), 32'd0);
        chk("rst.tick",    32'(tick),    32'd0);
        chk("rst.pend",    32'(pend),    32'd0);
        chk("rst.cfg_err", 32'(cfg_err), 32'd0);
        chk("rst.ready",   32'(cfg_ready), 32'd1);
        rst = 1'b0;

        // Default divisor 2 on ch0 only.
        run = 3'b001;
        step_chk("A1", 3'b001, 3'b000, 3'b000);
        step_chk("A2", 3'b000, 3'b001, 3'b000);
        step_chk("A3", 3'b001, 3'b000, 3'b000);
        step_chk("A4", 3'b000, 3'b001, 3'b000);

        // Write D=5 on the wrap cycle: must wait for the next boundary.
        cfg(1'b1, 0, 5);
        #1;
        chk("B0.ready", 32'(cfg_ready), 32'd1);
        step_chk("B1", 3'b001, 3'b000, 3'b001);
        cfg(1'b0, 0, 0);
        step_chk("B2", 3'b000, 3'b001, 3'b001);
        step_chk("B3", 3'b001, 3'b000, 3'b000);
        step_chk("B4", 3'b001, 3'b000, 3'b000);
        // D=3 written at cnt=1 of a D=5 period.
        cfg(1'b1, 0, 3);
        step_chk("B5", 3'b001, 3'b000, 3'b001);
        cfg(1'b1, 0, 7);
        #1;
        chk("B5.ready_busy", 32'(cfg_ready), 32'd0);
        step_chk("B6", 3'b000, 3'b000, 3'b001);
        cfg(1'b1, 1, 4);
        #1;
        chk("B6.ready_other", 32'(cfg_ready), 32'd1);
        step_chk("B7", 3'b000, 3'b001, 3'b011);
        cfg(1'b0, 0, 0);
        step_chk("B8",  3'b001, 3'b000, 3'b000);
        step_chk("B9",  3'b001, 3'b000, 3'b000);
        step_chk("B10", 3'b000, 3'b001, 3'b000);
        step_chk("B11", 3'b001, 3'b000, 3'b000);

        // Rejected configs; ch0 keeps D=3.
        cfg(1'b1, 1, 0);
        #1;
        chk("C0.ready", 32'(cfg_ready), 32'd1);
        step_chk("C1", 3'b001, 3'b000, 3'b000);
        chk("C1.cfg_err", 32'(cfg_err), 32'd1);
        cfg(1'b1, 3, 5);
        #1;
        chk("C1.ready_oor", 32'(cfg_ready), 32'd1);
        step_chk("C2", 3'b000, 3'b001, 3'b000);
        chk("C2.cfg_err", 32'(cfg_err), 32'd1);
        cfg(1'b0, 0, 0);
        step_chk("C3", 3'b001, 3'b000, 3'b000);
        chk("C3.cfg_err", 32'(cfg_err), 32'd0);

        // Idle channels apply the cycle after transfer.
        run = 3'b000;
        step_chk("D0", 3'b000, 3'b000, 3'b000);
        cfg(1'b1, 0, 4);
        step_chk("D1", 3'b000, 3'b000, 3'b001);
        cfg(1'b1, 1, 6);
        step_chk("D2", 3'b000, 3'b000, 3'b010);
        cfg(1'b0, 0, 0);
        step_chk("D3", 3'b000, 3'b000, 3'b000);

        // ch0 D=4, ch1 D=6, then sync realigns both.
        run = 3'b011;
        step_chk("E1", 3'b011, 3'b000, 3'b000);
        step_chk("E2", 3'b011, 3'b000, 3'b000);
        step_chk("E3", 3'b010, 3'b000, 3'b000);
        sync = 1'b1;
        step_chk("E4", 3'b011, 3'b000, 3'b000);
        sync = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] e_div;
            logic [2:0] e_tick;
            e_div  = {1'b0, (k % 6) < 3, (k % 4) < 2};
            e_tick = {1'b0, (k % 6) == 5, (k % 4) == 3};
            step();
            chk($sformatf("E5.%0d.div_clk", k), 32'(div_clk), 32'(e_div));
            chk($sformatf("E5.%0d.tick", k),    32'(tick),    32'(e_tick));
        end

        // D=1 on ch2 while ch0/ch1 are stopped.
        cfg(1'b1, 2, 1);
        #1;
        chk("F0.ready", 32'(cfg_ready), 32'd1);
        step_chk("F1", 3'b011, 3'b000, 3'b100);
        cfg(1'b0, 0, 0);
        run = 3'b100;
        step_chk("F2", 3'b100, 3'b100, 3'b000);
        step_chk("F3", 3'b100, 3'b100, 3'b000);
        step_chk("F4", 3'b100, 3'b100, 3'b000);

        // Reset mid-run restores divisor 2 everywhere.
        rst = 1'b1;
        step_chk("R1", 3'b000, 3'b000, 3'b000);
        chk("R1.cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        run = 3'b101;
        step_chk("R2", 3'b101, 3'b000, 3'b000);
        step_chk("R3", 3'b000, 3'b101, 3'b000);
        step_chk("R4", 3'b101, 3'b000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
